// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if -- bundle of every non-clock signal between the fetch/decode
// front end, the RAS controller and the return address stack.
//
// Signal groups (direction as seen by the controller, i.e. the slave side):
//   fetch predecode : if_call_i, if_ret_i, if_pc_i                  (in)
//   decode events   : id_valid_i, id_link_i, id_return_i, id_pc_i   (in)
//                     id_ready_o                                    (out)
//   recovery        : redirect_i                                    (in)
//   RAS predictor   : ras_push_o, ras_pop_o, ras_push_addr_o        (out)
//   RAS correction  : corr_addr_o, corr_link_o, corr_return_o       (out)
//   RAS flush       : fllush_o                                      (out)
//   status          : busy_o, spec_depth_o                          (out)
//
// The master modport is the environment that drives the front-end inputs;
// the slave modport is the controller itself.
interface ras_ctrl_if #(
  parameter int RAS_NUM = 8
) ();

  localparam int DW = $clog2(RAS_NUM) + 1;

  logic          if_call_i;
  logic          if_ret_i;
  logic [31:0]   if_pc_i;

  logic          id_valid_i;
  logic          id_link_i;
  logic          id_return_i;
  logic [31:0]   id_pc_i;
  logic          id_ready_o;

  logic          redirect_i;

  logic          ras_push_o;
  logic          ras_pop_o;
  logic [31:0]   ras_push_addr_o;

  logic [31:0]   corr_addr_o;
  logic          corr_link_o;
  logic          corr_return_o;
  logic          fllush_o;

  logic          busy_o;
  logic [DW-1:0] spec_depth_o;

  modport master (
    output if_call_i, if_ret_i, if_pc_i,
    output id_valid_i, id_link_i, id_return_i, id_pc_i,
    output redirect_i,
    input  id_ready_o,
    input  ras_push_o, ras_pop_o, ras_push_addr_o,
    input  corr_addr_o, corr_link_o, corr_return_o, fllush_o,
    input  busy_o, spec_depth_o
  );

  modport slave (
    input  if_call_i, if_ret_i, if_pc_i,
    input  id_valid_i, id_link_i, id_return_i, id_pc_i,
    input  redirect_i,
    output id_ready_o,
    output ras_push_o, ras_pop_o, ras_push_addr_o,
    output corr_addr_o, corr_link_o, corr_return_o, fllush_o,
    output busy_o, spec_depth_o
  );

endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl -- return address stack controller.
//
// Drives speculative pushes/pops from fetch predecode into the RAS, queues
// decode-time link/return corrections and replays them in order, and on a
// branch redirect drains the corrections, flushes the RAS for one cycle and
// suppresses fetch-side RAS traffic for HOLD_CYC cycles afterwards.
//
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ras_ctrl_if slave modport (fetch, decode, redirect inputs;
//            RAS push/pop/correction/flush outputs; busy and speculative
//            depth status)
//
// Parameters:
//   RAS_NUM  : RAS entry count (power of 2, must match the RAS and bus)
//   CQ_DEPTH : correction queue entries (power of 2, >= 2)
//   HOLD_CYC : post-flush fetch-suppress cycles (>= 1)
module ras_ctrl #(
  parameter int RAS_NUM  = 8,
  parameter int CQ_DEPTH = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  ras_ctrl_if.slave bus
);

  localparam int DW = $clog2(RAS_NUM) + 1;
  localparam int PW = $clog2(CQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYC) + 1;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(RAS_NUM);
  localparam logic [CW-1:0] CQ_FULL   = CW'(CQ_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    HOLD
  } state_e;

  typedef struct packed {
    logic        link;
    logic        ret;
    logic [31:0] pc;
  } cq_entry_t;

  state_e        state_q, state_d;

  cq_entry_t     cq_mem_q [CQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] spec_depth_q, spec_depth_d;
  logic [DW-1:0] commit_depth_q, commit_depth_d;

  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic [31:0]   push_addr_q, push_addr_d;
  logic          corr_link_q, corr_link_d;
  logic          corr_ret_q, corr_ret_d;
  logic [31:0]   corr_addr_q, corr_addr_d;
  logic          flush_q, flush_d;

  logic          cq_full;
  logic          cq_empty;
  logic          cq_accept;
  logic          cq_pop;
  cq_entry_t     cq_head;
  logic          fetch_push;
  logic          fetch_pop;

  assign cq_full   = (count_q == CQ_FULL);
  assign cq_empty  = (count_q == '0);
  // Events carrying neither flag have no effect on the RAS, so they are dropped.
  assign cq_accept = bus.id_valid_i && !cq_full && (bus.id_link_i || bus.id_return_i);
  // Corrections are only replayed while the RAS is not being flushed or held.
  assign cq_pop    = ((state_q == IDLE) || (state_q == DRAIN)) && !cq_empty;
  assign cq_head   = cq_mem_q[rd_ptr_q];

  assign fetch_push = (state_q == IDLE) && bus.if_call_i;
  assign fetch_pop  = (state_q == IDLE) && bus.if_ret_i;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A redirect while draining is absorbed because the
  // drain already ends in a flush; a redirect during flush/hold must drain
  // whatever arrived since, so it restarts DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (cq_empty) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = bus.redirect_i ? DRAIN : HOLD;
      end
      HOLD: begin
        if (bus.redirect_i) begin
          state_d = DRAIN;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic. Everything facing the RAS is
  // computed here and registered below, giving one cycle of latency.
  always_comb begin
    push_d         = fetch_push;
    // A lone pop on an empty speculative stack would underflow the RAS.
    pop_d          = fetch_pop && (fetch_push || (spec_depth_q != '0));
    push_addr_d    = (state_q == IDLE) ? (bus.if_pc_i + 32'd8) : push_addr_q;

    corr_link_d    = cq_pop && cq_head.link;
    corr_ret_d     = cq_pop && cq_head.ret;
    corr_addr_d    = cq_pop ? cq_head.pc : corr_addr_q;

    flush_d        = (state_d == FLUSH);
    hold_cnt_d     = (state_q == HOLD) ? (hold_cnt_q + HW'(1)) : '0;

    wr_ptr_d       = cq_accept ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d       = cq_pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d        = count_q + CW'(cq_accept) - CW'(cq_pop);

    // Once corrections have drained, the committed depth is the truth and
    // replaces whatever the speculative stack had drifted to.
    spec_depth_d   = spec_depth_q;
    if (state_q == FLUSH) begin
      spec_depth_d = commit_depth_q;
    end else if (fetch_push && !fetch_pop) begin
      if (spec_depth_q != DEPTH_MAX) spec_depth_d = spec_depth_q + DW'(1);
    end else if (fetch_pop && !fetch_push) begin
      if (spec_depth_q != '0) spec_depth_d = spec_depth_q - DW'(1);
    end

    commit_depth_d = commit_depth_q;
    if (cq_pop) begin
      if (cq_head.link && !cq_head.ret) begin
        if (commit_depth_q != DEPTH_MAX) commit_depth_d = commit_depth_q + DW'(1);
      end else if (cq_head.ret && !cq_head.link) begin
        if (commit_depth_q != '0) commit_depth_d = commit_depth_q - DW'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      hold_cnt_q     <= '0;
      spec_depth_q   <= '0;
      commit_depth_q <= '0;
      push_q         <= 1'b0;
      pop_q          <= 1'b0;
      push_addr_q    <= '0;
      corr_link_q    <= 1'b0;
      corr_ret_q     <= 1'b0;
      corr_addr_q    <= '0;
      flush_q        <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      hold_cnt_q     <= hold_cnt_d;
      spec_depth_q   <= spec_depth_d;
      commit_depth_q <= commit_depth_d;
      push_q         <= push_d;
      pop_q          <= pop_d;
      push_addr_q    <= push_addr_d;
      corr_link_q    <= corr_link_d;
      corr_ret_q     <= corr_ret_d;
      corr_addr_q    <= corr_addr_d;
      flush_q        <= flush_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (cq_accept) begin
      cq_mem_q[wr_ptr_q] <= '{link: bus.id_link_i, ret: bus.id_return_i, pc: bus.id_pc_i};
    end
  end

  assign bus.id_ready_o      = !cq_full;
  assign bus.ras_push_o      = push_q;
  assign bus.ras_pop_o       = pop_q;
  assign bus.ras_push_addr_o = push_addr_q;
  assign bus.corr_link_o     = corr_link_q;
  assign bus.corr_return_o   = corr_ret_q;
  assign bus.corr_addr_o     = corr_addr_q;
  assign bus.fllush_o        = flush_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.spec_depth_o    = spec_depth_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl -- self-checking bench for ras_ctrl with default parameters.
// Directed scenarios cover reset, push/pop, correction ordering, the
// drain/flush/hold sequence, redirect restart, saturation and reset during
// a drain; a randomized phase runs fetch/decode traffic against a queue
// based reference model of the stack depths and correction stream.
module tb_ras_ctrl;

  localparam int RAS_NUM  = 8;
  localparam int CQ_DEPTH = 4;
  localparam int HOLD_CYC = 2;

  typedef struct {
    bit          link;
    bit          ret;
    logic [31:0] pc;
  } corr_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  corr_t refQ[$];
  int    refSpec;
  int    refCommit;

  ras_ctrl_if #(.RAS_NUM(RAS_NUM)) bus ();

  ras_ctrl #(
    .RAS_NUM (RAS_NUM),
    .CQ_DEPTH(CQ_DEPTH),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives every front-end input for the coming clock edge.
  task automatic applyStimulus(input bit call, input bit ret, input logic [31:0] pc,
                               input bit v, input bit link, input bit rret,
                               input logic [31:0] idpc, input bit redir);
    bus.if_call_i   = call;
    bus.if_ret_i    = ret;
    bus.if_pc_i     = pc;
    bus.id_valid_i  = v;
    bus.id_link_i   = link;
    bus.id_return_i = rret;
    bus.id_pc_i     = idpc;
    bus.redirect_i  = redir;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; leaves the bench 1 unit after a rising edge.
  task automatic doReset();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit          seen;
    bit          call, ret, v, link, rret;
    logic [31:0] pc, idpc;
    bit          expPush, expPop, expLink, expRet;
    logic [31:0] expAddr, expCaddr;
    int          sizeBefore;
    corr_t       e;

    errors = 0;
    checks = 0;

    // Reset state, observed while reset is held and before any clock edge.
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_push", bus.ras_push_o, 0);
    checkOutput("rst_pop", bus.ras_pop_o, 0);
    checkOutput("rst_flush", bus.fllush_o, 0);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_ready", bus.id_ready_o, 1);
    checkOutput("rst_depth", bus.spec_depth_o, 0);
    checkOutput("rst_clink", bus.corr_link_o, 0);
    doReset();

    $display("[TB] call push and address");
    applyStimulus(1, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("call_push", bus.ras_push_o, 1);
    checkOutput("call_addr", bus.ras_push_addr_o, 32'h0000_1008);
    checkOutput("call_depth", bus.spec_depth_o, 1);
    applyStimulus(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("wrap_addr", bus.ras_push_addr_o, 32'h0000_0004);
    checkOutput("wrap_depth", bus.spec_depth_o, 2);

    $display("[TB] pop at empty stack");
    doReset();
    applyStimulus(0, 1, 32'h0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("empty_pop", bus.ras_pop_o, 0);
    checkOutput("empty_depth", bus.spec_depth_o, 0);

    $display("[TB] back-to-back corrections");
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 32'h0, (i < 4), 1, 0, 32'h2000 + 32'(4 * i), 0);
      checkOutput("b2b_ready", bus.id_ready_o, 1);
      tick();
      checkOutput("b2b_link", bus.corr_link_o, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) checkOutput("b2b_addr", bus.corr_addr_o, 32'h2000 + 32'(4 * (i - 1)));
    end

    $display("[TB] drain, flush, hold");
    doReset();
    applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h3000, 0);
    tick();
    checkOutput("dr_busy0", bus.busy_o, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h3010, 1);
    tick();
    checkOutput("dr_c1_link", bus.corr_link_o, 1);
    checkOutput("dr_c1_addr", bus.corr_addr_o, 32'h3000);
    checkOutput("dr_c1_busy", bus.busy_o, 1);
    applyStimulus(1, 0, 32'h5000, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("dr_c2_link", bus.corr_link_o, 1);
    checkOutput("dr_c2_addr", bus.corr_addr_o, 32'h3010);
    checkOutput("dr_c2_flush", bus.fllush_o, 0);
    checkOutput("dr_c2_push", bus.ras_push_o, 0);
    tick();
    checkOutput("dr_fl_flush", bus.fllush_o, 1);
    checkOutput("dr_fl_link", bus.corr_link_o, 0);
    checkOutput("dr_fl_push", bus.ras_push_o, 0);
    tick();
    checkOutput("dr_h1_flush", bus.fllush_o, 0);
    checkOutput("dr_h1_busy", bus.busy_o, 1);
    checkOutput("dr_h1_depth", bus.spec_depth_o, 2);
    checkOutput("dr_h1_push", bus.ras_push_o, 0);
    tick();
    checkOutput("dr_h2_busy", bus.busy_o, 1);
    checkOutput("dr_h2_push", bus.ras_push_o, 0);
    tick();
    checkOutput("dr_idle_busy", bus.busy_o, 0);
    checkOutput("dr_idle_push", bus.ras_push_o, 0);
    tick();
    checkOutput("dr_after_push", bus.ras_push_o, 1);
    checkOutput("dr_after_depth", bus.spec_depth_o, 3);

    $display("[TB] redirect during hold");
    doReset();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("rh_flush1", bus.fllush_o, 1);
    tick();
    checkOutput("rh_hold_flush", bus.fllush_o, 0);
    applyStimulus(0, 0, 32'h0, 1, 0, 1, 32'h4000, 1);
    tick();
    checkOutput("rh_busy", bus.busy_o, 1);
    checkOutput("rh_noflush", bus.fllush_o, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("rh_cret", bus.corr_return_o, 1);
    checkOutput("rh_caddr", bus.corr_addr_o, 32'h4000);
    tick();
    checkOutput("rh_flush2", bus.fllush_o, 1);
    tick();
    checkOutput("rh_flush2_end", bus.fllush_o, 0);
    checkOutput("rh_depth", bus.spec_depth_o, 0);

    $display("[TB] saturation and commit reload");
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, $urandom, 0, 0, 0, 32'h0, 0);
      tick();
      checkOutput("sat_depth", bus.spec_depth_o, (i + 1 > RAS_NUM) ? RAS_NUM : i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h6000 + 32'(i), 0);
      tick();
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.fllush_o === 1'b1) seen = 1;
      else tick();
    end
    checkOutput("sat_flush_seen", seen, 1);
    tick();
    checkOutput("sat_reload", bus.spec_depth_o, 3);

    $display("[TB] reset during drain");
    doReset();
    applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h7000, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h7004, 1);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rd_busy", bus.busy_o, 0);
    checkOutput("rd_ready", bus.id_ready_o, 1);
    checkOutput("rd_clink", bus.corr_link_o, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rd_post_flush", bus.fllush_o, 0);
      checkOutput("rd_post_clink", bus.corr_link_o, 0);
      checkOutput("rd_post_busy", bus.busy_o, 0);
    end

    $display("[TB] randomized traffic");
    doReset();
    refQ.delete();
    refSpec = 0;
    refCommit = 0;
    for (int n = 0; n < 300; n++) begin
      call = ($urandom_range(0, 99) < 40);
      ret  = ($urandom_range(0, 99) < 30);
      pc   = $urandom;
      v    = ($urandom_range(0, 99) < 60);
      link = $urandom_range(0, 1);
      rret = $urandom_range(0, 1);
      idpc = $urandom;
      applyStimulus(call, ret, pc, v, link, rret, idpc, 0);

      sizeBefore = refQ.size();
      checkOutput("rnd_ready", bus.id_ready_o, (sizeBefore < CQ_DEPTH));

      expPush = call;
      expAddr = pc + 32'd8;
      expPop  = ret && (call || refSpec > 0);
      if (call && !ret) refSpec = (refSpec < RAS_NUM) ? refSpec + 1 : refSpec;
      else if (ret && !call && refSpec > 0) refSpec = refSpec - 1;

      expLink  = 0;
      expRet   = 0;
      expCaddr = 32'h0;
      if (sizeBefore > 0) begin
        e = refQ.pop_front();
        expLink  = e.link;
        expRet   = e.ret;
        expCaddr = e.pc;
        if (e.link && !e.ret && refCommit < RAS_NUM) refCommit = refCommit + 1;
        else if (e.ret && !e.link && refCommit > 0) refCommit = refCommit - 1;
      end
      if (v && (link || rret) && sizeBefore < CQ_DEPTH) refQ.push_back('{link, rret, idpc});

      tick();
      checkOutput("rnd_push", bus.ras_push_o, expPush);
      checkOutput("rnd_pop", bus.ras_pop_o, expPop);
      checkOutput("rnd_paddr", bus.ras_push_addr_o, expAddr);
      checkOutput("rnd_depth", bus.spec_depth_o, refSpec);
      checkOutput("rnd_clink", bus.corr_link_o, expLink);
      checkOutput("rnd_cret", bus.corr_return_o, expRet);
      if (expLink || expRet) checkOutput("rnd_caddr", bus.corr_addr_o, expCaddr);
      checkOutput("rnd_busy", bus.busy_o, 0);
    end

    // Everything still queued will be replayed before the flush.
    while (refQ.size() > 0) begin
      e = refQ.pop_front();
      if (e.link && !e.ret && refCommit < RAS_NUM) refCommit = refCommit + 1;
      else if (e.ret && !e.link && refCommit > 0) refCommit = refCommit - 1;
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.fllush_o === 1'b1) seen = 1;
      else tick();
    end
    checkOutput("rnd_flush_seen", seen, 1);
    tick();
    checkOutput("rnd_reload", bus.spec_depth_o, refCommit);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
